meas_gate_ctrl: RTL and testbench

//  Sequences one frequency-meter measurement: clears the event counter, opens a gate of exact length, latches the result, then holds off.

---
 rtl/meas_pkg.sv | 24 ++
 rtl/meas_gate_ctrl_if.sv | 25 ++
 rtl/meas_gate_ctrl_tick_prescaler.sv | 22 ++
 rtl/meas_gate_ctrl.sv | 122 ++++++++++++
 tb/tb_meas_gate_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/meas_pkg.sv
// Shared encodings and constants for the frequency-meter gate controller.
package meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_LATCH,
    ST_HOLD
  } state_t;

  localparam int RANGE_MAX = 3;
  localparam int DECADE    = 10;

  // Terminal value of the decade stage: 10^range - 1 ticks per gate unit.
  function automatic logic [9:0] decade_last(input logic [1:0] range);
    int p;
    p = 1;
    for (int i = 0; i < RANGE_MAX; i++)
      if (i < int'(range)) p = p * DECADE;
    return 10'(p - 1);
  endfunction

endpackage

// File: rtl/meas_gate_ctrl_if.sv
// Control/status bundle between the measurement sequencer and the gate controller.
interface meas_gate_ctrl_if #(parameter int GATE_W = 16);
  logic              start;
  logic              continuous;
  logic [GATE_W-1:0] gate_ticks;
  logic              cnt_ovf;
  logic              cnt_small;
  logic              cnt_clr;
  logic              gate_en;
  logic              cnt_latch;
  logic              busy;
  logic              done;
  logic              ovf_flag;
  logic [1:0]        range_sel;

  modport master (
    output start, continuous, gate_ticks, cnt_ovf, cnt_small,
    input  cnt_clr, gate_en, cnt_latch, busy, done, ovf_flag, range_sel
  );

  modport slave (
    input  start, continuous, gate_ticks, cnt_ovf, cnt_small,
    output cnt_clr, gate_en, cnt_latch, busy, done, ovf_flag, range_sel
  );
endinterface

// File: rtl/meas_gate_ctrl_tick_prescaler.sv
// Restartable divide-by-TICK_DIV strobe; tick fires on the TICK_DIV-th cycle after restart.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int              CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (restart || cnt == '0)  cnt <= LAST;
    else                            cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0) && !restart;
endmodule

// File: rtl/meas_gate_ctrl.sv
// Frequency-meter gate sequencer: clear, timed gate, latch, hold-off.
// Define AUTO_RANGE_EN to step the gate decade from the overflow/small-count feedback.
module meas_gate_ctrl
  import meas_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int GATE_W     = 16,
  parameter int HOLD_TICKS = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  meas_gate_ctrl_if.slave bus
);
  // state   | meaning
  // IDLE    | waiting for start
  // ARM     | counter clear, sample gate length, restart prescaler
  // GATE    | counter enabled for G * 10^range ticks
  // LATCH   | result latch strobe, range update
  // HOLD    | hold-off, done on last cycle

  localparam int HOLD_CYC = HOLD_TICKS * TICK_DIV;
  localparam int HW       = $clog2(HOLD_CYC);

  state_t            state;
  logic              tick;
  logic [GATE_W-1:0] gate_cnt;
  logic [9:0]        dec_cnt;
  logic [9:0]        dec_last;
  logic [HW-1:0]     hold_cnt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_in  (clk_in),
    .rst     (rst),
    .restart (state == ST_ARM),
    .tick    (tick)
  );

  assign dec_last = decade_last(bus.range_sel);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.cnt_clr   <= 1'b0;
      bus.gate_en   <= 1'b0;
      bus.cnt_latch <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ovf_flag  <= 1'b0;
      bus.range_sel <= 2'd0;
      gate_cnt      <= '0;
      dec_cnt       <= '0;
      hold_cnt      <= '0;
    end else begin
      bus.cnt_clr   <= 1'b0;
      bus.cnt_latch <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state        <= ST_ARM;
            bus.cnt_clr  <= 1'b1;
            bus.busy     <= 1'b1;
            bus.ovf_flag <= 1'b0;
          end
        end
        ST_ARM: begin
          state       <= ST_GATE;
          bus.gate_en <= 1'b1;
          gate_cnt    <= (bus.gate_ticks == '0) ? '0 : bus.gate_ticks - 1'b1;
          dec_cnt     <= dec_last;
        end
        ST_GATE: begin
          if (bus.cnt_ovf) bus.ovf_flag <= 1'b1;
          // Decade stage counts ticks inside each gate unit; gate_cnt counts units.
          if (tick) begin
            if (dec_cnt != '0) begin
              dec_cnt <= dec_cnt - 1'b1;
            end else if (gate_cnt != '0) begin
              gate_cnt <= gate_cnt - 1'b1;
              dec_cnt  <= dec_last;
            end else begin
              state         <= ST_LATCH;
              bus.gate_en   <= 1'b0;
              bus.cnt_latch <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          state    <= ST_HOLD;
          hold_cnt <= HW'(HOLD_CYC - 1);
`ifdef AUTO_RANGE_EN
          if ((bus.cnt_ovf || bus.ovf_flag) && bus.range_sel != 2'd0)
            bus.range_sel <= bus.range_sel - 2'd1;
          else if (bus.cnt_small && bus.range_sel != 2'(RANGE_MAX))
            bus.range_sel <= bus.range_sel + 2'd1;
`else
          bus.range_sel <= 2'd0;
`endif
        end
        ST_HOLD: begin
          if (hold_cnt == HW'(1)) bus.done <= 1'b1;
          if (hold_cnt == '0) begin
            if (bus.continuous) begin
              state        <= ST_ARM;
              bus.cnt_clr  <= 1'b1;
              bus.ovf_flag <= 1'b0;
            end else begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Directed bench for meas_gate_ctrl at TICK_DIV=4, HOLD_TICKS=2.
module tb_meas_gate_ctrl;
  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  meas_gate_ctrl_if #(.GATE_W(16)) bus ();

  meas_gate_ctrl #(.TICK_DIV(4), .GATE_W(16), .HOLD_TICKS(2)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called with the ARM cycle sampled; returns with the done cycle sampled.
  task automatic observe(input int budget, output int clr_n, output int gate_n,
                         output int gfirst, output int latch_n, output int l2d,
                         output bit ok);
    int latch_at;
    clr_n = 0; gate_n = 0; gfirst = -1; latch_n = 0; l2d = -1; ok = 0; latch_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.cnt_clr) clr_n++;
      if (bus.gate_en) begin
        if (gfirst < 0) gfirst = i;
        gate_n++;
      end
      if (bus.cnt_latch) begin
        latch_n++;
        latch_at = i;
      end
      if (bus.done) begin
        l2d = i - latch_at;
        ok  = 1;
        break;
      end
      tick();
    end
  endtask

  int  c_clr, c_gate, c_first, c_latch, c_l2d, lost;
  bit  c_ok;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.continuous = 0; bus.gate_ticks = '0;
    bus.cnt_ovf = 0; bus.cnt_small = 0;
    repeat (3) tick();
    chk("rst_outs", {bus.cnt_clr, bus.gate_en, bus.cnt_latch, bus.busy,
                     bus.done, bus.ovf_flag, bus.range_sel}, 0);
    rst = 1'b0;
    tick();

    // single shot, G=3
    bus.gate_ticks = 16'd3;
    pulse_start();
    chk("t1_busy_arm", bus.busy, 1);
    observe(200, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
    chk("t1_done_seen", c_ok, 1);
    chk("t1_clr_len", c_clr, 1);
    chk("t1_gate_first", c_first, 1);
    chk("t1_gate_len", c_gate, 12);
    chk("t1_latch_len", c_latch, 1);
    chk("t1_latch_to_done", c_l2d, 8);
    tick();
    chk("t1_idle", {bus.busy, bus.done}, 0);

    // G=0 behaves as 1
    bus.gate_ticks = 16'd0;
    pulse_start();
    observe(200, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
    chk("t2_done_seen", c_ok, 1);
    chk("t2_gate_len", c_gate, 4);
    tick();
    chk("t2_idle", bus.busy, 0);

    // continuous, three runs, drop continuous in run 3
    bus.gate_ticks = 16'd1;
    bus.continuous = 1'b1;
    pulse_start();
    for (int r = 1; r <= 3; r++) begin
      if (r == 3) bus.continuous = 1'b0;
      observe(200, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
      chk($sformatf("t3_run%0d_done", r), c_ok, 1);
      chk($sformatf("t3_run%0d_gate", r), c_gate, 4);
      tick();
      if (r < 3) chk($sformatf("t3_run%0d_rearm", r), {bus.cnt_clr, bus.busy}, 2'b11);
      else       chk("t3_idle_after", {bus.cnt_clr, bus.busy}, 2'b00);
    end

    // overflow flag stickiness, start ignored in GATE
    bus.gate_ticks = 16'd5;
    pulse_start();
    repeat (6) tick();
    chk("t4_in_gate", bus.gate_en, 1);
    bus.cnt_ovf = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.cnt_ovf = 1'b0;
    bus.start   = 1'b0;
    chk("t4_ovf_set", bus.ovf_flag, 1);
    lost = 0;
    c_ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.ovf_flag) lost++;
      if (bus.done) begin
        c_ok = 1;
        break;
      end
      tick();
    end
    chk("t4_done_seen", c_ok, 1);
    chk("t4_ovf_held", lost, 0);
    tick();
    chk("t4_no_restart", bus.busy, 0);
    pulse_start();
    chk("t4_ovf_cleared", {bus.cnt_clr, bus.ovf_flag}, 2'b10);
    observe(400, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
    chk("t4_gate_len", c_gate, 20);
    tick();

    // async reset mid-gate
    bus.gate_ticks = 16'd4;
    pulse_start();
    repeat (3) tick();
    chk("t5_gate_on", bus.gate_en, 1);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_drop", {bus.gate_en, bus.busy}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_after", {bus.gate_en, bus.busy, bus.cnt_clr}, 0);

`ifdef AUTO_RANGE_EN
    bus.gate_ticks = 16'd3;
    bus.cnt_small  = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      pulse_start();
      observe(20000, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
      chk($sformatf("t6_run%0d_done", r), c_ok, 1);
      if (r == 2) chk("t6_run2_gate", c_gate, 120);
      chk($sformatf("t6_run%0d_range", r), bus.range_sel, (r < 3) ? r : 3);
      tick();
    end
    bus.cnt_small  = 1'b0;
    bus.gate_ticks = 16'd1;
    pulse_start();
    repeat (10) tick();
    bus.cnt_ovf = 1'b1;
    tick();
    bus.cnt_ovf = 1'b0;
    c_ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (bus.done) begin
        c_ok = 1;
        break;
      end
      tick();
    end
    chk("t6_ovf_done", c_ok, 1);
    chk("t6_ovf_range", bus.range_sel, 2);
    tick();
`else
    bus.gate_ticks = 16'd2;
    bus.cnt_small  = 1'b1;
    pulse_start();
    observe(200, c_clr, c_gate, c_first, c_latch, c_l2d, c_ok);
    chk("t6_fixed_gate", c_gate, 8);
    chk("t6_fixed_range", bus.range_sel, 0);
    bus.cnt_small = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
